// File: rtl/echo_tof_meter.sv
// echo_tof_meter
//   Measures the time of flight from a transmit burst start to the first
//   echo pulse, in clk cycles, and converts it to water depth in mm.
//   Echoes inside the blanking window (transmit ring-down) are ignored.
//   A listen timeout ends a measurement that sees no echo. The depth is
//   saturated to 16 bits.
//
// Ports
//   clk            in   system clock (50 MHz nominal)
//   res_n          in   asynchronous active-low reset
//   system_work_en in   measurement enable; low aborts a running measurement
//   tx_start       in   level; rising edge marks the transmit burst start
//   echo_in        in   level; rising edge marks the echo
//   busy           out  high while a measurement is in progress
//   tof_cycles     out  last measured cycle count
//   water_deep     out  last depth in mm, saturated to 16'hFFFF
//   depth_valid    out  one-cycle strobe with a new depth
//   echo_timeout   out  one-cycle strobe when no echo came before MAX_CYCLES
module echo_tof_meter #(
  parameter int unsigned BLANK_CYCLES = 50000,
  parameter int unsigned MAX_CYCLES   = 4400000,
  parameter int unsigned DEPTH_K      = 983,
  parameter int unsigned CNT_W        = 24
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             system_work_en,
  input  logic             tx_start,
  input  logic             echo_in,
  output logic             busy,
  output logic [CNT_W-1:0] tof_cycles,
  output logic [15:0]      water_deep,
  output logic             depth_valid,
  output logic             echo_timeout
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_BLANK  = 3'd1,
    ST_LISTEN = 3'd2,
    ST_CALC   = 3'd3,
    ST_TOUT   = 3'd4
  } state_t;

  // Last counter value of each window; the transition happens on that cycle
  // so the next window starts with the following count.
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] MAX_LAST   = CNT_W'(MAX_CYCLES - 1);
  localparam logic [33:0]      K34        = 34'(DEPTH_K);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] tof_nxt;
  logic [15:0]      depth_nxt;
  logic             busy_nxt;
  logic             valid_nxt;
  logic             timeout_nxt;
  logic             tx_d;
  logic             echo_d;
  logic             tx_edge;
  logic             echo_edge;
  logic [33:0]      prod;
  logic [33:0]      quot;
  logic [15:0]      depth_sat;

  assign tx_edge   = tx_start & ~tx_d;
  assign echo_edge = echo_in & ~echo_d;

  // Q16 scaling: mm = (cycles * DEPTH_K) >> 16, clamped to 16 bits.
  assign prod      = 34'(tof_cycles) * K34;
  assign quot      = prod >> 16;
  assign depth_sat = (quot > 34'd65535) ? 16'hFFFF : quot[15:0];

  // Input edge-detect history registers.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      tx_d   <= 1'b0;
      echo_d <= 1'b0;
    end else begin
      tx_d   <= tx_start;
      echo_d <= echo_in;
    end
  end

  // State, counter and registered outputs.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      tof_cycles   <= '0;
      water_deep   <= 16'd0;
      busy         <= 1'b0;
      depth_valid  <= 1'b0;
      echo_timeout <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      tof_cycles   <= tof_nxt;
      water_deep   <= depth_nxt;
      busy         <= busy_nxt;
      depth_valid  <= valid_nxt;
      echo_timeout <= timeout_nxt;
    end
  end

  // Next-state and next-output logic. A low enable in any active state
  // returns to IDLE without a strobe and leaves the results untouched.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    tof_nxt     = tof_cycles;
    depth_nxt   = water_deep;
    valid_nxt   = 1'b0;
    timeout_nxt = 1'b0;
    case (state)
      ST_IDLE: begin
        if (system_work_en && tx_edge) begin
          state_nxt = ST_BLANK;
          cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_BLANK: begin
        if (!system_work_en) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          if (cnt == BLANK_LAST) begin
            state_nxt = ST_LISTEN;
          end else begin
            state_nxt = ST_BLANK;
          end
        end
      end
      ST_LISTEN: begin
        if (!system_work_en) begin
          state_nxt = ST_IDLE;
        end else begin
          cnt_nxt = cnt + {{(CNT_W-1){1'b0}}, 1'b1};
          // Echo takes priority over the timeout on the last listen cycle.
          if (echo_edge) begin
            tof_nxt   = cnt;
            state_nxt = ST_CALC;
          end else if (cnt == MAX_LAST) begin
            state_nxt = ST_TOUT;
          end else begin
            state_nxt = ST_LISTEN;
          end
        end
      end
      ST_CALC: begin
        if (!system_work_en) begin
          state_nxt = ST_IDLE;
        end else begin
          depth_nxt = depth_sat;
          valid_nxt = 1'b1;
          state_nxt = ST_IDLE;
        end
      end
      ST_TOUT: begin
        if (!system_work_en) begin
          state_nxt = ST_IDLE;
        end else begin
          timeout_nxt = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
    busy_nxt = (state_nxt != ST_IDLE);
  end

endmodule

// File: tb/tb_echo_tof_meter.sv
module tb_echo_tof_meter;

  // Windows shortened so every scenario fits a short run; DEPTH_K scaled by
  // 1000 so that cycle counts 1000x smaller give the same depths in mm and
  // saturation is reachable within the shortened listen window.
  localparam int unsigned BLANK = 50;
  localparam int unsigned MAXC  = 4400;
  localparam int unsigned KQ16  = 983000;
  localparam int unsigned CW    = 24;

  logic          clk;
  logic          res_n;
  logic          system_work_en;
  logic          tx_start;
  logic          echo_in;
  logic          busy;
  logic [CW-1:0] tof_cycles;
  logic [15:0]   water_deep;
  logic          depth_valid;
  logic          echo_timeout;

  echo_tof_meter #(
    .BLANK_CYCLES(BLANK),
    .MAX_CYCLES  (MAXC),
    .DEPTH_K     (KQ16),
    .CNT_W       (CW)
  ) dut (
    .clk           (clk),
    .res_n         (res_n),
    .system_work_en(system_work_en),
    .tx_start      (tx_start),
    .echo_in       (echo_in),
    .busy          (busy),
    .tof_cycles    (tof_cycles),
    .water_deep    (water_deep),
    .depth_valid   (depth_valid),
    .echo_timeout  (echo_timeout)
  );

  typedef struct {
    bit is_to;
    int cyc;
    int tof;
    int depth;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  int   last_tof   = 0;
  int   last_depth = 0;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Count rising edges; the edge that samples a driven input is cyc+1.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_value(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  function automatic int depth_of(input int n);
    longint unsigned p;
    longint unsigned q;
    p = longint'(n) * longint'(KQ16);
    q = p >> 16;
    return (q > 65535) ? 65535 : int'(q);
  endfunction

  // Scoreboard: every strobe must match the oldest expected result.
  always @(negedge clk) begin
    if (res_n && (depth_valid || echo_timeout)) begin
      if (sb.size() == 0) begin
        check_value("stray_strobe", {30'd0, depth_valid, echo_timeout}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_value("strobe_cycle", cyc, e.cyc);
        check_value("timeout_flag", echo_timeout, e.is_to);
        check_value("valid_flag", depth_valid, !e.is_to);
        check_value("tof_cycles", tof_cycles, e.tof);
        check_value("water_deep", water_deep, e.depth);
        check_value("busy_at_strobe", busy, 0);
      end
    end
  end

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic start_burst(output int t);
    tx_start = 1'b1;
    t = cyc + 1;
    repeat (3) @(negedge clk);
    tx_start = 1'b0;
  endtask

  // Raise echo so that it is sampled when the counter reads n.
  task automatic echo_at(input int t, input int n, input bit expect_hit);
    exp_t e;
    wait_until(t + n - 1);
    echo_in = 1'b1;
    if (expect_hit) begin
      e.is_to = 1'b0;
      e.cyc   = t + n + 1;
      e.tof   = n;
      e.depth = depth_of(n);
      last_tof   = n;
      last_depth = e.depth;
      sb.push_back(e);
    end
    repeat (4) @(negedge clk);
    echo_in = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_value("drain", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int   t;
    exp_t e;
    res_n = 1'b0;
    system_work_en = 1'b0;
    tx_start = 1'b0;
    echo_in = 1'b0;
    repeat (4) @(negedge clk);
    check_value("rst_busy", busy, 0);
    check_value("rst_tof", tof_cycles, 0);
    check_value("rst_depth", water_deep, 0);
    check_value("rst_valid", depth_valid, 0);
    check_value("rst_timeout", echo_timeout, 0);
    res_n = 1'b1;
    repeat (3) @(negedge clk);

    // Nominal measurement.
    system_work_en = 1'b1;
    start_burst(t);
    check_value("busy_running", busy, 1);
    echo_at(t, 100, 1'b1);
    wait_drain(50);
    check_value("busy_after", busy, 0);

    // Echo inside blanking ignored; later echo counts; a third is ignored.
    start_burst(t);
    echo_at(t, 20, 1'b0);
    echo_at(t, 60, 1'b1);
    echo_at(t, 80, 1'b0);
    wait_drain(50);

    // Echo already high when LISTEN opens makes no edge.
    start_burst(t);
    echo_at(t, BLANK - 1, 1'b0);
    echo_at(t, 70, 1'b1);
    wait_drain(50);

    // First listen cycle.
    start_burst(t);
    echo_at(t, BLANK, 1'b1);
    wait_drain(50);

    // Timeout: results held.
    start_burst(t);
    e.is_to = 1'b1;
    e.cyc   = t + MAXC;
    e.tof   = last_tof;
    e.depth = last_depth;
    sb.push_back(e);
    wait_drain(MAXC + 50);
    check_value("busy_after_to", busy, 0);

    // Largest unsaturated depth, then echo on the timeout cycle saturates.
    start_burst(t);
    echo_at(t, 4369, 1'b1);
    wait_drain(50);
    start_burst(t);
    echo_at(t, MAXC - 1, 1'b1);
    wait_drain(50);

    // Abort during LISTEN: no strobe, results held.
    start_burst(t);
    wait_until(t + 79);
    system_work_en = 1'b0;
    @(negedge clk);
    check_value("abort_busy", busy, 0);
    echo_at(t, 90, 1'b0);
    start_burst(t);
    check_value("disabled_busy", busy, 0);
    repeat (5) @(negedge clk);
    check_value("held_tof", tof_cycles, last_tof);
    check_value("held_depth", water_deep, last_depth);
    system_work_en = 1'b1;

    // tx_start during LISTEN ignored; count runs from the first burst.
    start_burst(t);
    wait_until(t + 70);
    tx_start = 1'b1;
    repeat (3) @(negedge clk);
    tx_start = 1'b0;
    echo_at(t, 100, 1'b1);
    wait_drain(50);

    // Retrigger restarts the count from 1.
    start_burst(t);
    echo_at(t, 60, 1'b1);
    wait_drain(50);

    // Reset mid-LISTEN clears everything; a lone echo then does nothing.
    start_burst(t);
    wait_until(t + 70);
    res_n = 1'b0;
    #1;
    check_value("mid_rst_busy", busy, 0);
    check_value("mid_rst_tof", tof_cycles, 0);
    check_value("mid_rst_depth", water_deep, 0);
    repeat (2) @(negedge clk);
    res_n = 1'b1;
    last_tof = 0;
    last_depth = 0;
    @(negedge clk);
    echo_in = 1'b1;
    repeat (4) @(negedge clk);
    echo_in = 1'b0;
    repeat (20) @(negedge clk);
    check_value("post_rst_busy", busy, 0);
    check_value("post_rst_depth", water_deep, 0);
    check_value("post_rst_tof", tof_cycles, 0);
    check_value("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
